// File: rtl/dmem_pkg.sv
// Shared types and constants for the data/stack memory block.
package dmem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int OP_W        = 2;
  localparam int STACK_WORDS = 64;

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer unit: owns SP, full/empty status and sticky overflow/underflow flags.
module stack_ptr_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_BASE  = 2**ADDR_W - 1,
  parameter int STACK_LIMIT = 2**ADDR_W - STACK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              push_ok,
  output logic              pop_ok,
  output logic [ADDR_W-1:0] stk_addr
);

  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] FULL_C = ADDR_W'(STACK_LIMIT - 1);
  localparam logic [ADDR_W-1:0] ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  assign push_ok  = push_req & ~full_q;
  assign pop_ok   = pop_req & ~empty_q;
  // PUSH writes at SP; POP reads the slot just above it.
  assign stk_addr = pop_req ? (sp_q + ONE_C) : sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q - ONE_C;
    end else if (pop_ok) begin
      sp_d = sp_q + ONE_C;
    end else begin
      sp_d = sp_q;
    end
    full_d  = (sp_d == FULL_C);
    empty_d = (sp_d == BASE_C);
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push_req && full_q) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (pop_req && empty_q) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= BASE_C;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sp        = sp_q;
  assign stk_full  = full_q;
  assign stk_empty = empty_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: rtl/data_stack_mem.sv
// Single-port data RAM with integrated hardware stack, zero-fill after reset,
// registered read data and a valid/ready request interface.
module data_stack_mem
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_BASE  = 2**ADDR_W - 1,
  parameter int STACK_LIMIT = 2**ADDR_W - STACK_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              err_clr
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_C    = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  op_e               op_s;
  logic              fire_s;
  logic              push_req_s, pop_req_s;
  logic              push_ok_s, pop_ok_s;
  logic [ADDR_W-1:0] stk_addr_s;

  logic              mem_we_s;
  logic              mem_re_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign op_s       = op_e'(req_op);
  assign fire_s     = req_valid & ready_q;
  assign push_req_s = fire_s && (op_s == OP_PUSH);
  assign pop_req_s  = fire_s && (op_s == OP_POP);

  stack_ptr_ctrl #(
    .ADDR_W      (ADDR_W),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req_s),
    .pop_req   (pop_req_s),
    .err_clr   (err_clr),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .push_ok   (push_ok_s),
    .pop_ok    (pop_ok_s),
    .stk_addr  (stk_addr_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Single RAM port shared by the zero-fill sweep and the accepted request.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_addr_s  = cnt_q;
    mem_wdata_s = {DATA_W{1'b0}};
    case (state_q)
      ST_INIT: begin
        mem_we_s = 1'b1;
      end
      ST_RUN: begin
        if (fire_s) begin
          case (op_s)
            OP_LOAD: begin
              mem_re_s   = 1'b1;
              mem_addr_s = req_addr;
            end
            OP_STORE: begin
              mem_we_s    = 1'b1;
              mem_addr_s  = req_addr;
              mem_wdata_s = req_wdata;
            end
            OP_PUSH: begin
              mem_we_s    = push_ok_s;
              mem_addr_s  = stk_addr_s;
              mem_wdata_s = req_wdata;
            end
            OP_POP: begin
              mem_re_s   = pop_ok_s;
              mem_addr_s = stk_addr_s;
            end
            default: begin
              mem_we_s = 1'b0;
            end
          endcase
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_valid_d = mem_re_s;
    if (mem_re_s) begin
      rd_data_d = mem[mem_addr_s];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= {ADDR_W{1'b0}};
      ready_q    <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign req_ready = ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_data_stack_mem.sv
// Self-checking bench for data_stack_mem: directed table, stack corner cases,
// mid-stream reset and randomized traffic against an array/counter reference model.
module tb_data_stack_mem;

  localparam int DEPTH = 256;
  localparam int BASE  = 255;
  localparam int LIMIT = 192;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] sp;
  logic       stk_full;
  logic       stk_empty;
  logic       err_ovf;
  logic       err_unf;
  logic       err_clr;

  data_stack_mem dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0] mem_m [DEPTH];
  int         sp_m;
  bit         ovf_m, unf_m, vld_m;
  logic [7:0] rd_m;
  int         init_left;

  typedef struct {
    bit       v;
    bit [1:0] op;
    bit [7:0] a;
    bit [7:0] d;
    bit       clr;
    bit       e_vld;
    bit [7:0] e_rd;
    bit [7:0] e_sp;
    bit       e_empty;
    bit       e_unf;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    sp_m      = BASE;
    ovf_m     = 1'b0;
    unf_m     = 1'b0;
    vld_m     = 1'b0;
    rd_m      = 8'h00;
    init_left = DEPTH;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"},  int'(rd_valid),  int'(vld_m));
    chk({tag, ".rd_data"},   int'(rd_data),   int'(rd_m));
    chk({tag, ".sp"},        int'(sp),        sp_m);
    chk({tag, ".stk_full"},  int'(stk_full),  int'(sp_m == LIMIT - 1));
    chk({tag, ".stk_empty"}, int'(stk_empty), int'(sp_m == BASE));
    chk({tag, ".err_ovf"},   int'(err_ovf),   int'(ovf_m));
    chk({tag, ".err_unf"},   int'(err_unf),   int'(unf_m));
    chk({tag, ".req_ready"}, int'(req_ready), int'(init_left == 0));
  endtask

  // Drive one cycle of stimulus, advance the model by the spec rules, compare.
  task automatic cycle(input string tag, input bit v, input bit [1:0] op,
                       input bit [7:0] a, input bit [7:0] d, input bit clr);
    bit fire;
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    err_clr   = clr;
    fire      = v && (init_left == 0);
    @(posedge clk);
    #1;
    vld_m = 1'b0;
    if (clr) begin
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end
    if (fire) begin
      case (op)
        2'd0: begin rd_m = mem_m[a]; vld_m = 1'b1; end
        2'd1: mem_m[a] = d;
        2'd2: begin
          if (sp_m == LIMIT - 1) ovf_m = 1'b1;
          else begin mem_m[sp_m] = d; sp_m = sp_m - 1; end
        end
        default: begin
          if (sp_m == BASE) unf_m = 1'b1;
          else begin sp_m = sp_m + 1; rd_m = mem_m[sp_m]; vld_m = 1'b1; end
        end
      endcase
    end
    if (init_left > 0) init_left--;
    check_all(tag);
    req_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".sp"},        int'(sp),        8'hFF);
    chk({tag, ".rd_data"},   int'(rd_data),   8'h00);
    chk({tag, ".rd_valid"},  int'(rd_valid),  1'b0);
    chk({tag, ".err_ovf"},   int'(err_ovf),   1'b0);
    chk({tag, ".err_unf"},   int'(err_unf),   1'b0);
    chk({tag, ".req_ready"}, int'(req_ready), 1'b0);
    chk({tag, ".stk_empty"}, int'(stk_empty), 1'b1);
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < DEPTH; i++) cycle(tag, 1'b1, 2'd0, 8'(i), 8'h5A, 1'b0);
  endtask

  initial begin
    bit [1:0] op;
    int       r;

    tbl[0]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 8'h7F, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 8'h10, 8'h00, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 8'h00, 8'h11, 1'b0, 1'b0, 8'hA5, 8'hFE, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 8'h00, 8'h22, 1'b0, 1'b0, 8'hA5, 8'hFD, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'h22, 8'hFE, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11, 8'hFF, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 8'hFF, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 8'hFF, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 8'hFF, 1'b1, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    err_clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    run_init("init");

    for (int i = 0; i < 13; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl%0d.vld", i),   int'(rd_valid),  int'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.rd", i),    int'(rd_data),   int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d.sp", i),    int'(sp),        int'(tbl[i].e_sp));
      chk($sformatf("tbl%0d.empty", i), int'(stk_empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.unf", i),   int'(err_unf),   int'(tbl[i].e_unf));
    end

    // Fill the stack to its limit, then one push too many.
    for (int i = 0; i < 64; i++) cycle("fill", 1'b1, 2'd2, 8'h00, 8'(i + 1), 1'b0);
    chk("fill.sp", int'(sp), 8'hBF);
    chk("fill.full", int'(stk_full), 1'b1);
    cycle("ovf", 1'b1, 2'd2, 8'h00, 8'hEE, 1'b0);
    chk("ovf.flag", int'(err_ovf), 1'b1);
    chk("ovf.sp", int'(sp), 8'hBF);
    cycle("ovf_load", 1'b1, 2'd0, 8'hBF, 8'h00, 1'b0);
    chk("ovf_load.rd", int'(rd_data), 8'h00);
    chk("ovf_load.vld", int'(rd_valid), 1'b1);
    cycle("top_pop", 1'b1, 2'd3, 8'h00, 8'h00, 1'b1);
    chk("top_pop.rd", int'(rd_data), 8'd64);
    chk("top_pop.ovf_clr", int'(err_ovf), 1'b0);

    // Randomized traffic: push-heavy phase then pop-heavy phase.
    for (int i = 0; i < 1200; i++) begin
      r = int'($urandom_range(0, 99));
      if (i < 600) op = (r < 55) ? 2'd2 : (r < 75) ? 2'd3 : (r < 88) ? 2'd0 : 2'd1;
      else         op = (r < 55) ? 2'd3 : (r < 75) ? 2'd2 : (r < 88) ? 2'd0 : 2'd1;
      cycle("rand", ($urandom_range(0, 7) != 0), op, 8'($urandom),
            8'($urandom), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of traffic.
    cycle("pre_rst", 1'b1, 2'd2, 8'h00, 8'h33, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_init("reinit");
    cycle("post_load", 1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
    chk("post_load.rd", int'(rd_data), 8'h00);
    cycle("post_pop", 1'b1, 2'd3, 8'h00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
